// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic GEMM array: feeder state encoding and
// sizing helpers reused by the array and drain stages.
package sa_pkg;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feeder_state_t;

   function automatic int sa_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter must hold the longest phase length without wrapping.
   function automatic int sa_cnt_w(input int streamLen, input int drainLen);
      return $clog2(sa_max(streamLen, drainLen) + 1);
   endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Tile handshake and array-edge bus of the operand feeder.
interface systolic_operand_feeder_if #(
   parameter int M          = 4,
   parameter int K          = 4,
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8
);

   logic                        in_valid;
   logic                        in_ready;
   logic [M*K*DATA_WIDTH-1:0]   a_tile;
   logic [K*N*DATA_WIDTH-1:0]   b_tile;
   logic [M*DATA_WIDTH-1:0]     a_edge;
   logic [M-1:0]                a_edge_valid;
   logic [N*DATA_WIDTH-1:0]     b_edge;
   logic [N-1:0]                b_edge_valid;
   logic                        clear_acc;
   logic                        busy;
   logic                        done;

   modport master (
      output in_valid, a_tile, b_tile,
      input  in_ready, a_edge, a_edge_valid, b_edge, b_edge_valid,
             clear_acc, busy, done
   );

   modport slave (
      input  in_valid, a_tile, b_tile,
      output in_ready, a_edge, a_edge_valid, b_edge, b_edge_valid,
             clear_acc, busy, done
   );

endinterface

// File: rtl/systolic_operand_feeder_skew_lane.sv
// One skewed edge lane: presents element t-OFFSET of a latched operand vector,
// or zero with valid low when that index falls outside the vector.
module sa_skew_lane
   import sa_pkg::*;
#(
   parameter int LEN    = 4,
   parameter int OFFSET = 0,
   parameter int DW     = 8,
   parameter int CNT_W  = 4
) (
   input  logic [LEN*DW-1:0] vec_i,
   input  logic [CNT_W-1:0]  t_i,
   input  logic              en_i,
   output logic [DW-1:0]     data_o,
   output logic              valid_o
);

   always_comb begin
      data_o  = '0;
      valid_o = 1'b0;
      for (int k = 0; k < LEN; k++) begin
         if (en_i && (int'(t_i) == k + OFFSET)) begin
            data_o  = vec_i[k*DW +: DW];
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Latches an A/B tile pair and streams it diagonally skewed into the systolic
// array edges, then waits for in-flight MACs to drain before pulsing done.
module systolic_operand_feeder
   import sa_pkg::*;
#(
   parameter int M            = 4,
   parameter int K            = 4,
   parameter int N            = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int DRAIN_CYCLES = M + N
) (
   input logic                  clk,
   input logic                  reset,
   systolic_operand_feeder_if.slave bus
);

   localparam int DW    = DATA_WIDTH;
   localparam int T     = K + sa_max(M, N) - 1;
   localparam int CNT_W = sa_cnt_w(T, DRAIN_CYCLES);

   feeder_state_t          state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [M*K*DW-1:0]      aTile_q, aTile_d;
   logic [K*N*DW-1:0]      bTile_q, bTile_d;
   logic                   clearAcc_q, clearAcc_d;
   logic                   done_q, done_d;
   logic [M*DW-1:0]        aEdge_q, aEdge_d;
   logic [M-1:0]           aValid_q, aValid_d;
   logic [N*DW-1:0]        bEdge_q, bEdge_d;
   logic [N-1:0]           bValid_q, bValid_d;
   logic                   streamNext;
   logic [K*DW-1:0]        bCol [N];

   // Next-state logic; tiles are taken straight from the bus on accept so the
   // edge registers can be loaded with t=0 operands in the same edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      aTile_d    = aTile_q;
      bTile_d    = bTile_q;
      clearAcc_d = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               aTile_d    = bus.a_tile;
               bTile_d    = bus.b_tile;
               state_d    = STREAM;
               cnt_d      = '0;
               clearAcc_d = 1'b1;
            end
         end
         STREAM: begin
            if (cnt_q == CNT_W'(T - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign streamNext = (state_d == STREAM);

   // B is stored row-major, so each column lane needs its elements regathered.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         bCol[j] = '0;
         for (int k = 0; k < K; k++) begin
            bCol[j][k*DW +: DW] = bTile_d[(k*N+j)*DW +: DW];
         end
      end
   end

   for (genvar i = 0; i < M; i++) begin : gA
      sa_skew_lane #(.LEN(K), .OFFSET(i), .DW(DW), .CNT_W(CNT_W)) uLane (
         .vec_i   (aTile_d[i*K*DW +: K*DW]),
         .t_i     (cnt_d),
         .en_i    (streamNext),
         .data_o  (aEdge_d[i*DW +: DW]),
         .valid_o (aValid_d[i])
      );
   end

   for (genvar j = 0; j < N; j++) begin : gB
      sa_skew_lane #(.LEN(K), .OFFSET(j), .DW(DW), .CNT_W(CNT_W)) uLane (
         .vec_i   (bCol[j]),
         .t_i     (cnt_d),
         .en_i    (streamNext),
         .data_o  (bEdge_d[j*DW +: DW]),
         .valid_o (bValid_d[j])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         aTile_q    <= '0;
         bTile_q    <= '0;
         clearAcc_q <= 1'b0;
         done_q     <= 1'b0;
         aEdge_q    <= '0;
         aValid_q   <= '0;
         bEdge_q    <= '0;
         bValid_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         aTile_q    <= aTile_d;
         bTile_q    <= bTile_d;
         clearAcc_q <= clearAcc_d;
         done_q     <= done_d;
         aEdge_q    <= aEdge_d;
         aValid_q   <= aValid_d;
         bEdge_q    <= bEdge_d;
         bValid_q   <= bValid_d;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.busy         = (state_q != IDLE);
   assign bus.clear_acc    = clearAcc_q;
   assign bus.done         = done_q;
   assign bus.a_edge       = aEdge_q;
   assign bus.a_edge_valid = aValid_q;
   assign bus.b_edge       = bEdge_q;
   assign bus.b_edge_valid = bValid_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for the operand feeder: a 2x2x2 instance and a 2x3x4 instance
// sharing one clock and reset.
module tb_systolic_operand_feeder;

   logic clk = 1'b0;
   logic reset;
   int   testsRun  = 0;
   int   failCount = 0;

   always #5 clk = ~clk;

   systolic_operand_feeder_if #(.M(2), .K(2), .N(2), .DATA_WIDTH(8)) busS ();
   systolic_operand_feeder_if #(.M(2), .K(3), .N(4), .DATA_WIDTH(8)) busN ();

   systolic_operand_feeder #(.M(2), .K(2), .N(2), .DATA_WIDTH(8), .DRAIN_CYCLES(4)) dutS (
      .clk   (clk),
      .reset (reset),
      .bus   (busS.slave)
   );

   systolic_operand_feeder #(.M(2), .K(3), .N(4), .DATA_WIDTH(8), .DRAIN_CYCLES(6)) dutN (
      .clk   (clk),
      .reset (reset),
      .bus   (busN.slave)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdleS(input string tag);
      checkOutput({tag, "_inready"}, 64'(busS.in_ready), 64'h1);
      checkOutput({tag, "_busy"},    64'(busS.busy),     64'h0);
      checkOutput({tag, "_done"},    64'(busS.done),     64'h0);
      checkOutput({tag, "_clear"},   64'(busS.clear_acc), 64'h0);
      checkOutput({tag, "_aedge"},   64'({busS.a_edge_valid, busS.a_edge}), 64'h0);
      checkOutput({tag, "_bedge"},   64'({busS.b_edge_valid, busS.b_edge}), 64'h0);
   endtask

   task automatic applyStimulus(input logic [31:0] aTile, input logic [31:0] bTile);
      busS.a_tile   = aTile;
      busS.b_tile   = bTile;
      busS.in_valid = 1'b1;
      stepCycle();
      busS.in_valid = 1'b0;
   endtask

   // Steps from cycle 'startCyc' until done or a bound, returning the cycle index.
   task automatic waitDoneS(input int startCyc, output int cyc);
      cyc = startCyc;
      while (!busS.done && cyc < 40) begin
         stepCycle();
         cyc++;
      end
   endtask

   task automatic waitDoneN(input int startCyc, output int cyc);
      cyc = startCyc;
      while (!busN.done && cyc < 40) begin
         stepCycle();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int accepts, lastAccept, doneCnt, lastDone, violations;
      logic [15:0] expAEdge  [6] = '{16'h0001, 16'h0402, 16'h0503, 16'h0600, 16'h0000, 16'h0000};
      logic [1:0]  expAValid [6] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
      logic [31:0] expBEdge  [6] = '{32'h00000011, 32'h00001221, 32'h00132231,
                                     32'h14233200, 32'h24330000, 32'h34000000};
      logic [3:0]  expBValid [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

      reset         = 1'b1;
      busS.in_valid = 1'b0;
      busS.a_tile   = '0;
      busS.b_tile   = '0;
      busN.in_valid = 1'b0;
      busN.a_tile   = '0;
      busN.b_tile   = '0;

      // Reset values, during reset and after release with no traffic
      repeat (3) stepCycle();
      checkIdleS("rst");
      checkOutput("rstN_inready", 64'(busN.in_ready), 64'h1);
      checkOutput("rstN_edges", 64'({busN.a_edge_valid, busN.a_edge, busN.b_edge_valid, busN.b_edge}), 64'h0);
      reset = 1'b0;
      repeat (3) stepCycle();
      checkIdleS("idle");

      // Basic 2x2 tile: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
      checkOutput("t2_c0_inready", 64'(busS.in_ready), 64'h1);
      applyStimulus(32'h04030201, 32'h08070605);
      checkOutput("t2_c1_clear", 64'(busS.clear_acc), 64'h1);
      checkOutput("t2_c1_busy",  64'(busS.busy), 64'h1);
      checkOutput("t2_c1_a",     64'(busS.a_edge), 64'h0001);
      checkOutput("t2_c1_av",    64'(busS.a_edge_valid), 64'h1);
      checkOutput("t2_c1_b",     64'(busS.b_edge), 64'h0005);
      checkOutput("t2_c1_bv",    64'(busS.b_edge_valid), 64'h1);
      stepCycle();
      checkOutput("t2_c2_clear", 64'(busS.clear_acc), 64'h0);
      checkOutput("t2_c2_a",     64'(busS.a_edge), 64'h0302);
      checkOutput("t2_c2_b",     64'(busS.b_edge), 64'h0607);
      checkOutput("t2_c2_v",     64'({busS.a_edge_valid, busS.b_edge_valid}), 64'hF);
      stepCycle();
      checkOutput("t2_c3_a",     64'(busS.a_edge), 64'h0400);
      checkOutput("t2_c3_av",    64'(busS.a_edge_valid), 64'h2);
      checkOutput("t2_c3_b",     64'(busS.b_edge), 64'h0800);
      checkOutput("t2_c3_bv",    64'(busS.b_edge_valid), 64'h2);
      stepCycle();
      checkOutput("t2_c4_edges", 64'({busS.a_edge_valid, busS.a_edge, busS.b_edge_valid, busS.b_edge}), 64'h0);
      checkOutput("t2_c4_busy",  64'(busS.busy), 64'h1);
      checkOutput("t2_c4_inready", 64'(busS.in_ready), 64'h0);
      repeat (3) stepCycle();
      checkOutput("t2_c7_done",  64'(busS.done), 64'h0);
      checkOutput("t2_c7_busy",  64'(busS.busy), 64'h1);
      stepCycle();
      checkOutput("t2_c8_done",  64'(busS.done), 64'h1);
      checkOutput("t2_c8_inready", 64'(busS.in_ready), 64'h1);
      checkOutput("t2_c8_busy",  64'(busS.busy), 64'h0);
      stepCycle();
      checkOutput("t2_c9_done",  64'(busS.done), 64'h0);

      // Signed extremes pass through unmodified
      applyStimulus(32'h00000080, 32'h0000007F);
      checkOutput("t3_a", 64'(busS.a_edge), 64'h0080);
      checkOutput("t3_b", 64'(busS.b_edge), 64'h007F);
      waitDoneS(1, cyc);
      checkOutput("t3_done_cycle", 64'(cyc), 64'd8);
      stepCycle();

      // in_valid held high: accepts only at c0 and in the done cycle c8
      accepts = 0; lastAccept = -1; doneCnt = 0; lastDone = -1; violations = 0;
      busS.a_tile   = 32'h04030201;
      busS.b_tile   = 32'h08070605;
      busS.in_valid = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c == 10) busS.in_valid = 1'b0;
         if (busS.in_valid && busS.in_ready) begin
            accepts++;
            lastAccept = c;
         end
         if (busS.busy && busS.in_ready) violations++;
         if (busS.done) begin
            doneCnt++;
            lastDone = c;
         end
         stepCycle();
      end
      checkOutput("t4_accepts",     64'(accepts), 64'd2);
      checkOutput("t4_last_accept", 64'(lastAccept), 64'd8);
      checkOutput("t4_done_count",  64'(doneCnt), 64'd2);
      checkOutput("t4_last_done",   64'(lastDone), 64'd16);
      checkOutput("t4_ready_busy",  64'(violations), 64'd0);

      // Reset pulse at t=1 aborts the tile without done
      applyStimulus(32'h04030201, 32'h08070605);
      stepCycle();
      checkOutput("t5_t1_a", 64'(busS.a_edge), 64'h0302);
      reset = 1'b1;
      #1;
      checkIdleS("t5_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (busS.done) doneCnt++;
         stepCycle();
      end
      checkOutput("t5_no_done", 64'(doneCnt), 64'd0);
      applyStimulus(32'h04030201, 32'h08070605);
      checkOutput("t5_rerun_a", 64'(busS.a_edge), 64'h0001);
      checkOutput("t5_rerun_b", 64'(busS.b_edge), 64'h0005);
      waitDoneS(1, cyc);
      checkOutput("t5_rerun_done_cycle", 64'(cyc), 64'd8);
      stepCycle();

      // Non-square M=2, K=3, N=4: T=6, drain 6
      busN.a_tile   = 48'h060504030201;
      busN.b_tile   = 96'h34333231_24232221_14131211;
      busN.in_valid = 1'b1;
      stepCycle();
      busN.in_valid = 1'b0;
      checkOutput("t6_clear", 64'(busN.clear_acc), 64'h1);
      for (int t = 0; t < 6; t++) begin
         checkOutput($sformatf("t6_t%0d_a", t),  64'(busN.a_edge), 64'(expAEdge[t]));
         checkOutput($sformatf("t6_t%0d_av", t), 64'(busN.a_edge_valid), 64'(expAValid[t]));
         checkOutput($sformatf("t6_t%0d_b", t),  64'(busN.b_edge), 64'(expBEdge[t]));
         checkOutput($sformatf("t6_t%0d_bv", t), 64'(busN.b_edge_valid), 64'(expBValid[t]));
         stepCycle();
      end
      checkOutput("t6_drain_busy",  64'(busN.busy), 64'h1);
      checkOutput("t6_drain_edges", 64'({busN.a_edge_valid, busN.a_edge, busN.b_edge_valid, busN.b_edge}), 64'h0);
      waitDoneN(7, cyc);
      checkOutput("t6_done_cycle", 64'(cyc), 64'd13);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
